// File: rtl/rib_rr_arbiter.sv
// rib_rr_arbiter: registered round-robin arbiter for the shared riscv_bus master port.
// Instruction fetch (m1) owns the bus by default. Load/store (m0), JTAG debug (m2)
// and the UART loader (m3) rotate round-robin in the order 0->2->3->0. A tenure
// counter forces a one-cycle fetch slot after MAX_TENURE cycles of ownership.
// Ports:
//   clk, rst        clock, async active-low reset
//   m_req_i/m_we_i  per-master request / write enable (bit k = master k)
//   m_addr_i        master k address at [k*ADDR_W +: ADDR_W]
//   m_data_i        master k write data at [k*DATA_W +: DATA_W]
//   m_data_o        read data broadcast to all masters (= bus_data_i)
//   grant_o         registered one-hot grant
//   bus_*_o         slave-side request/we/addr/data muxed from the granted master
//   bus_data_i      read data from slave decode
//   hold_flag_o     registered pipeline hold, high whenever fetch is not granted
module rib_rr_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MAX_TENURE = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            m_req_i,
   input  logic [3:0]            m_we_i,
   input  logic [4*ADDR_W-1:0]   m_addr_i,
   input  logic [4*DATA_W-1:0]   m_data_i,
   output logic [DATA_W-1:0]     m_data_o,
   output logic [3:0]            grant_o,
   output logic                  bus_req_o,
   output logic                  bus_we_o,
   output logic [ADDR_W-1:0]     bus_addr_o,
   output logic [DATA_W-1:0]     bus_data_o,
   input  logic [DATA_W-1:0]     bus_data_i,
   output logic                  hold_flag_o
);

   localparam int unsigned      TEN_W       = $clog2(MAX_TENURE);
   localparam logic [TEN_W-1:0] TEN_LAST    = TEN_W'(MAX_TENURE - 1);
   localparam logic [3:0]       FETCH_GRANT = 4'b0010;
   localparam logic [3:0]       NF_MASK     = 4'b1101;

   typedef enum logic [1:0] {IDLE, OWN, YIELD} state_t;

   state_t           state_q, state_d;
   logic [1:0]       owner_q, owner_d;
   logic [1:0]       rr_q, rr_d;
   logic [TEN_W-1:0] ten_q, ten_d;
   logic [3:0]       grant_d;
   logic             hold_d;
   logic [1:0]       search_start;
   logic [2:0]       pick;

   // Successor in the non-fetch rotation 0->2->3->0.
   function automatic logic [1:0] rr_next(input logic [1:0] m);
      logic [1:0] n;
      case (m)
         2'd0:    n = 2'd2;
         2'd2:    n = 2'd3;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

   // First requester at or after start in the rotation; returns {found, index}.
   function automatic logic [2:0] rr_pick(input logic [3:0] nf, input logic [1:0] start);
      logic [1:0] c0, c1, c2;
      logic [2:0] r;
      c0 = (start == 2'd1) ? 2'd0 : start;
      c1 = rr_next(c0);
      c2 = rr_next(c1);
      r  = 3'b000;
      if (nf[c2]) r = {1'b1, c2};
      if (nf[c1]) r = {1'b1, c1};
      if (nf[c0]) r = {1'b1, c0};
      return r;
   endfunction

   // On release the search starts just past the old owner; otherwise at rr_ptr.
   assign search_start = (state_q == OWN) ? rr_next(owner_q) : rr_q;
   assign pick         = rr_pick(m_req_i & NF_MASK, search_start);

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      ten_d   = ten_q;
      case (state_q)
         IDLE, YIELD: begin
            if (pick[2]) begin
               state_d = OWN;
               owner_d = pick[1:0];
               ten_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         OWN: begin
            if (!m_req_i[owner_q]) begin
               rr_d = rr_next(owner_q);
               if (pick[2]) begin
                  owner_d = pick[1:0];
                  ten_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else if (ten_q == TEN_LAST) begin
               state_d = YIELD;
               rr_d    = rr_next(owner_q);
            end else begin
               // ten_q < TEN_LAST here, so the increment never wraps.
               ten_d = ten_q + TEN_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      grant_d = (state_d == OWN) ? (4'b0001 << owner_d) : FETCH_GRANT;
      hold_d  = (state_d == OWN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         owner_q     <= 2'd0;
         rr_q        <= 2'd0;
         ten_q       <= '0;
         grant_o     <= FETCH_GRANT;
         hold_flag_o <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_q        <= rr_d;
         ten_q       <= ten_d;
         grant_o     <= grant_d;
         hold_flag_o <= hold_d;
      end
   end

   // AND-OR bus mux driven by the one-hot grant.
   always_comb begin
      bus_addr_o = '0;
      bus_data_o = '0;
      for (int k = 0; k < 4; k++) begin
         if (grant_o[k]) begin
            bus_addr_o = bus_addr_o | m_addr_i[k*ADDR_W +: ADDR_W];
            bus_data_o = bus_data_o | m_data_i[k*DATA_W +: DATA_W];
         end
      end
   end

   assign bus_req_o = |(m_req_i & grant_o);
   assign bus_we_o  = |(m_we_i & m_req_i & grant_o);
   assign m_data_o  = bus_data_i;

endmodule
